vga_pattern_engine: RTL

- Parametrised, animated VGA test-pattern generator.
- Sits between `hvsync_generator` and the TinyVGA PMOD output mapping in the top level.
- Pattern mode is selectable at run time and changes only on frame boundaries.
- A frame counter drives scrolling and blinking animations.
- Colour, sync and blanking outputs are registered and aligned to one cycle of latency.

---
 rtl/vga_pattern_engine.sv | 115 +++++++++++
 1 files changed

// File: rtl/vga_pattern_engine.sv
// vga_pattern_engine: animated VGA test-pattern generator with frame-synchronous mode switching
module vga_pattern_engine #(
  parameter int   CW         = 2,
  parameter int   ZONE_SHIFT = 6,
  parameter int   H_ACT      = 640,
  parameter int   V_ACT      = 480,
  parameter int   H_LAST     = 799,
  parameter int   V_LAST     = 524,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    hpos,
  input  logic [9:0]    vpos,
  input  logic          display_on,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [2:0]    mode,
  input  logic          mode_valid,
  input  logic          pause,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [7:0]    frame_cnt,
  output logic [2:0]    mode_active
);
  logic [2:0]    pending_mode_q, pending_mode_d, mode_active_q, mode_active_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic          hsync_q, vsync_q;
  logic          tick, border;
  logic [2:0]    z;
  logic [7:0]    gx, gy, xr, ck, zv, v, unused_v;

  assign tick     = hpos == 10'(H_LAST) && vpos == 10'(V_LAST);
  assign z        = hpos[ZONE_SHIFT+2:ZONE_SHIFT];
  assign gx       = hpos[9:2];
  assign gy       = vpos[8:1];
  assign xr       = hpos[7:0] ^ vpos[7:0];
  assign ck       = {8{hpos[5] ^ vpos[5]}};
  assign border   = hpos == 10'd0 || hpos == 10'(H_ACT-1) || vpos == 10'd0 || vpos == 10'(V_ACT-1);
  assign unused_v = v;

  // Per-zone value for the composite ZONES pattern
  always_comb begin
    zv = 8'hff;
    case (z)
      3'd0: zv = gx;
      3'd1: zv = gy;
      3'd2: zv = xr;
      3'd3: zv = ck;
      3'd4: zv = gx + gy;
      3'd5: zv = xr + gy;
      3'd6: zv = ~xr;
      default: zv = 8'hff;
    endcase
  end

  // Pattern value for the mode being rendered this frame
  always_comb begin
    v = '0;
    case (mode_active_q)
      3'd0: v = zv;
      3'd1: v = gx + frame_cnt_q;
      3'd2: v = (hpos[7:0] + frame_cnt_q) ^ vpos[7:0];
      3'd3: v = {8{hpos[5] ^ vpos[5] ^ frame_cnt_q[5]}};
      3'd5: v = frame_cnt_q;
      3'd6: v = border ? 8'hff : 8'h00;
      default: v = '0;
    endcase
  end

  // Next-state: mode capture, frame-boundary update, blanked colour mapping
  always_comb begin
    pending_mode_d = mode_valid ? mode : pending_mode_q;
    mode_active_d  = tick ? (mode_valid ? mode : pending_mode_q) : mode_active_q;
    frame_cnt_d    = tick && !pause ? frame_cnt_q + 8'd1 : frame_cnt_q;
    r_d = !display_on ? '0 : mode_active_q == 3'd4 ? {CW{z[2]}} : v[7 -: CW];
    g_d = !display_on ? '0 : mode_active_q == 3'd4 ? {CW{z[1]}} : v[5 -: CW];
    b_d = !display_on ? '0 : mode_active_q == 3'd4 ? {CW{z[0]}} : v[3 -: CW];
  end

  // State and one-cycle output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_mode_q <= '0;
      mode_active_q  <= '0;
      frame_cnt_q    <= '0;
      r_q            <= '0;
      g_q            <= '0;
      b_q            <= '0;
      hsync_q        <= SYNC_IDLE;
      vsync_q        <= SYNC_IDLE;
    end else begin
      pending_mode_q <= pending_mode_d;
      mode_active_q  <= mode_active_d;
      frame_cnt_q    <= frame_cnt_d;
      r_q            <= r_d;
      g_q            <= g_d;
      b_q            <= b_d;
      hsync_q        <= hsync_in;
      vsync_q        <= vsync_in;
    end
  end

  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign frame_cnt   = frame_cnt_q;
  assign mode_active = mode_active_q;
endmodule
